// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: horizontal/vertical counters, syncs,
// pixel request/valid strobes, pixel coordinates and gated pixel output.
module vga_timing_gen #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_FRONT = 10,
  parameter bit          H_POL   = 1'b0,
  parameter bit          V_POL   = 1'b0,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned RGB_W   = 16
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [RGB_W-1:0] pix_data,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_req,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             line_start
);

  localparam int unsigned H_TOTAL_I = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL_I = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned H_ST_I    = H_SYNC + H_BACK;
  localparam int unsigned V_ST_I    = V_SYNC + V_BACK;
  localparam int unsigned H_END_I   = H_ST_I + H_VALID - 1;
  localparam int unsigned V_END_I   = V_ST_I + V_VALID - 1;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL_I - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL_I - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ST      = CNT_W'(H_ST_I);
  localparam logic [CNT_W-1:0] H_END     = CNT_W'(H_END_I);
  localparam logic [CNT_W-1:0] H_REQ_ST  = CNT_W'(H_ST_I - 1);
  localparam logic [CNT_W-1:0] H_REQ_END = CNT_W'(H_END_I - 1);
  localparam logic [CNT_W-1:0] V_ST      = CNT_W'(V_ST_I);
  localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_END_I);

  logic             run;
  logic [CNT_W-1:0] cnt_h;
  logic [CNT_W-1:0] cnt_v;

  // Counters only advance once run has been high for a cycle, so an en rise
  // always starts with one cycle parked at (0,0).
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      run   <= 1'b0;
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      run <= en;
      if (en && run) begin
        if (cnt_h == H_LAST) begin
          cnt_h <= '0;
          cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + ONE;
        end else begin
          cnt_h <= cnt_h + ONE;
        end
      end else begin
        cnt_h <= '0;
        cnt_v <= '0;
      end
    end
  end

  logic v_act;
  logic h_act;
  logic h_req;

  assign v_act = (cnt_v >= V_ST) && (cnt_v <= V_END);
  assign h_act = (cnt_h >= H_ST) && (cnt_h <= H_END);
  assign h_req = (cnt_h >= H_REQ_ST) && (cnt_h <= H_REQ_END);

  always_comb begin
    hsync       = ~H_POL;
    vsync       = ~V_POL;
    pix_req     = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '1;
    pix_y       = '1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    rgb         = '0;
    if (run) begin
      hsync       = (cnt_h < H_SYNC_C) ? H_POL : ~H_POL;
      vsync       = (cnt_v < V_SYNC_C) ? V_POL : ~V_POL;
      pix_valid   = h_act && v_act;
      pix_req     = h_req && v_act;
      frame_start = (cnt_h == '0) && (cnt_v == '0);
      line_start  = (cnt_h == '0);
      // Coordinates refer to the pixel shown on the following cycle.
      if (h_req && v_act) begin
        pix_x = cnt_h + ONE - H_ST;
        pix_y = cnt_v - V_ST;
      end
      if (h_act && v_act) begin
        rgb = pix_data;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing and a tiny 10x6 config
// with active-high syncs, checked against a cycle-position model.
module tb_vga_timing_gen;

  logic        vga_clk = 1'b0;
  logic        d_rst, d_en, s_rst, s_en;
  logic [15:0] d_pix_data, s_pix_data, d_rgb, s_rgb;
  logic        d_hsync, d_vsync, d_pix_req, d_pix_valid, d_frame_start, d_line_start;
  logic        s_hsync, s_vsync, s_pix_req, s_pix_valid, s_frame_start, s_line_start;
  logic [11:0] d_pix_x, d_pix_y, s_pix_x, s_pix_y;

  int checks = 0;
  int errors = 0;
  int c;
  logic [15:0] sb_q[$];

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut_d (
    .vga_clk(vga_clk), .sys_rst(d_rst), .en(d_en), .pix_data(d_pix_data),
    .rgb(d_rgb), .hsync(d_hsync), .vsync(d_vsync), .pix_req(d_pix_req),
    .pix_valid(d_pix_valid), .pix_x(d_pix_x), .pix_y(d_pix_y),
    .frame_start(d_frame_start), .line_start(d_line_start)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_VALID(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .vga_clk(vga_clk), .sys_rst(s_rst), .en(s_en), .pix_data(s_pix_data),
    .rgb(s_rgb), .hsync(s_hsync), .vsync(s_vsync), .pix_req(s_pix_req),
    .pix_valid(s_pix_valid), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .frame_start(s_frame_start), .line_start(s_line_start)
  );

  task automatic test_reset;
    d_rst = 1'b1; d_en = 1'b1; s_rst = 1'b1; s_en = 1'b0;
    d_pix_data = 16'h0; s_pix_data = 16'h0;
    repeat (5) @(negedge vga_clk);
    checks++; if (d_hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync: got %b exp 1", d_hsync); end
    checks++; if (d_vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync: got %b exp 1", d_vsync); end
    checks++; if (d_rgb !== 16'h0) begin errors++; $display("FAIL rst_rgb: got %h exp 0", d_rgb); end
    checks++; if (d_pix_x !== 12'hFFF) begin errors++; $display("FAIL rst_pix_x: got %h exp fff", d_pix_x); end
    checks++; if (d_pix_y !== 12'hFFF) begin errors++; $display("FAIL rst_pix_y: got %h exp fff", d_pix_y); end
    checks++; if (d_frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b exp 0", d_frame_start); end
    checks++; if (d_pix_req !== 1'b0) begin errors++; $display("FAIL rst_pix_req: got %b exp 0", d_pix_req); end
    d_rst = 1'b0; s_rst = 1'b0;
    @(negedge vga_clk);
    checks++; if (d_frame_start !== 1'b1) begin errors++; $display("FAIL rel_frame_start: got %b exp 1", d_frame_start); end
    checks++; if (d_hsync !== 1'b0) begin errors++; $display("FAIL rel_hsync: got %b exp 0", d_hsync); end
    checks++; if (d_line_start !== 1'b1) begin errors++; $display("FAIL rel_line_start: got %b exp 1", d_line_start); end
    c = 0;
  endtask

  task automatic test_lines;
    int h, last_ls, low_cnt;
    logic exp_hs;
    last_ls = -1; low_cnt = 0;
    for (int i = 0; i < 2400; i++) begin
      h = c % 800;
      exp_hs = (h < 96) ? 1'b0 : 1'b1;
      checks++; if (d_hsync !== exp_hs) begin errors++; $display("FAIL line_hsync c=%0d: got %b exp %b", c, d_hsync, exp_hs); end
      checks++; if (d_line_start !== (h == 0)) begin errors++; $display("FAIL line_start c=%0d: got %b exp %b", c, d_line_start, (h == 0)); end
      checks++; if (d_frame_start !== (c == 0)) begin errors++; $display("FAIL line_frame_start c=%0d: got %b exp %b", c, d_frame_start, (c == 0)); end
      if (d_hsync === 1'b0) low_cnt++;
      if (d_line_start === 1'b1) begin
        if (last_ls >= 0) begin
          checks++; if (c - last_ls !== 800) begin errors++; $display("FAIL line_period: got %0d exp 800", c - last_ls); end
        end
        last_ls = c;
      end
      if (h == 799) begin
        checks++; if (low_cnt !== 96) begin errors++; $display("FAIL hsync_width: got %0d exp 96", low_cnt); end
        low_cnt = 0;
      end
      @(negedge vga_clk); c++;
    end
  endtask

  task automatic test_pixels;
    int h, v, vcnt;
    logic exp_req, exp_valid;
    logic [15:0] exp_rgb;
    vcnt = 0;
    d_pix_data = 16'hFFFF;
    while (c < 38 * 800) begin
      h = c % 800; v = c / 800;
      exp_req   = (h >= 143) && (h <= 782) && (v >= 35) && (v <= 514);
      exp_valid = (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
      checks++; if (d_pix_req !== exp_req) begin errors++; $display("FAIL pix_req c=%0d: got %b exp %b", c, d_pix_req, exp_req); end
      checks++; if (d_pix_valid !== exp_valid) begin errors++; $display("FAIL pix_valid c=%0d: got %b exp %b", c, d_pix_valid, exp_valid); end
      if (exp_req) begin
        checks++; if (d_pix_x !== 12'(h - 143)) begin errors++; $display("FAIL pix_x c=%0d: got %0d exp %0d", c, d_pix_x, h - 143); end
        checks++; if (d_pix_y !== 12'(v - 35)) begin errors++; $display("FAIL pix_y c=%0d: got %0d exp %0d", c, d_pix_y, v - 35); end
      end else begin
        checks++; if (d_pix_x !== 12'hFFF || d_pix_y !== 12'hFFF) begin errors++; $display("FAIL pix_xy_idle c=%0d: got %h/%h exp fff/fff", c, d_pix_x, d_pix_y); end
      end
      if (d_pix_valid === 1'b1) begin
        vcnt++;
        if (sb_q.size() == 0) begin
          checks++; errors++; $display("FAIL rgb_sb c=%0d: got output with no pending request", c);
        end else begin
          exp_rgb = sb_q.pop_front();
          checks++; if (d_rgb !== exp_rgb) begin errors++; $display("FAIL rgb c=%0d: got %0d exp %0d", c, d_rgb, exp_rgb); end
        end
      end else begin
        checks++; if (d_rgb !== 16'h0) begin errors++; $display("FAIL rgb_blank c=%0d: got %h exp 0", c, d_rgb); end
      end
      if (exp_req) begin
        sb_q.push_back(16'(h - 143));
        d_pix_data = 16'(h - 143);
      end
      if (h == 799) begin
        if (v >= 35) begin
          checks++; if (vcnt !== 640) begin errors++; $display("FAIL valid_per_line v=%0d: got %0d exp 640", v, vcnt); end
        end
        vcnt = 0;
      end
      @(negedge vga_clk); c++;
    end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d pending exp 0", sb_q.size()); end
  endtask

  task automatic test_small_frame;
    int h, v, fs_cnt, last_fs;
    logic exp_req, exp_valid;
    logic [15:0] exp_rgb;
    fs_cnt = 0; last_fs = -1;
    s_pix_data = 16'hFFFF;
    s_en = 1'b1;
    @(negedge vga_clk);
    c = 0;
    for (int i = 0; i < 130; i++) begin
      h = c % 10; v = (c / 10) % 6;
      exp_req   = (h >= 3) && (h <= 6) && (v >= 2) && (v <= 4);
      exp_valid = (h >= 4) && (h <= 7) && (v >= 2) && (v <= 4);
      checks++; if (s_hsync !== (h < 2)) begin errors++; $display("FAIL s_hsync c=%0d: got %b exp %b", c, s_hsync, (h < 2)); end
      checks++; if (s_vsync !== (v < 1)) begin errors++; $display("FAIL s_vsync c=%0d: got %b exp %b", c, s_vsync, (v < 1)); end
      checks++; if (s_frame_start !== (h == 0 && v == 0)) begin errors++; $display("FAIL s_frame_start c=%0d: got %b exp %b", c, s_frame_start, (h == 0 && v == 0)); end
      checks++; if (s_line_start !== (h == 0)) begin errors++; $display("FAIL s_line_start c=%0d: got %b exp %b", c, s_line_start, (h == 0)); end
      checks++; if (s_pix_req !== exp_req) begin errors++; $display("FAIL s_pix_req c=%0d: got %b exp %b", c, s_pix_req, exp_req); end
      checks++; if (s_pix_valid !== exp_valid) begin errors++; $display("FAIL s_pix_valid c=%0d: got %b exp %b", c, s_pix_valid, exp_valid); end
      if (exp_req) begin
        checks++; if (s_pix_x !== 12'(h - 3) || s_pix_y !== 12'(v - 2)) begin errors++; $display("FAIL s_pix_xy c=%0d: got %0d/%0d exp %0d/%0d", c, s_pix_x, s_pix_y, h - 3, v - 2); end
      end
      if (s_pix_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++; $display("FAIL s_rgb_sb c=%0d: got output with no pending request", c);
        end else begin
          exp_rgb = sb_q.pop_front();
          checks++; if (s_rgb !== exp_rgb) begin errors++; $display("FAIL s_rgb c=%0d: got %h exp %h", c, s_rgb, exp_rgb); end
        end
      end else begin
        checks++; if (s_rgb !== 16'h0) begin errors++; $display("FAIL s_rgb_blank c=%0d: got %h exp 0", c, s_rgb); end
      end
      if (exp_req) begin
        exp_rgb = 16'h8000 | 16'((v - 2) * 16 + (h - 3));
        sb_q.push_back(exp_rgb);
        s_pix_data = exp_rgb;
      end
      if (s_frame_start === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          checks++; if (c - last_fs !== 60) begin errors++; $display("FAIL s_frame_period: got %0d exp 60", c - last_fs); end
        end
        last_fs = c;
      end
      @(negedge vga_clk); c++;
    end
    checks++; if (fs_cnt !== 3) begin errors++; $display("FAIL s_frame_count: got %0d exp 3", fs_cnt); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL s_sb_drain: got %0d pending exp 0", sb_q.size()); end
  endtask

  task automatic test_enable_drop;
    while (c % 60 != 35) begin
      @(negedge vga_clk); c++;
    end
    checks++; if (s_pix_valid !== 1'b1) begin errors++; $display("FAIL en_pre_valid: got %b exp 1", s_pix_valid); end
    s_en = 1'b0;
    @(negedge vga_clk);
    checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin errors++; $display("FAIL en_off_sync: got %b/%b exp 0/0", s_hsync, s_vsync); end
    checks++; if (s_pix_req !== 1'b0 || s_pix_valid !== 1'b0) begin errors++; $display("FAIL en_off_strobe: got %b/%b exp 0/0", s_pix_req, s_pix_valid); end
    checks++; if (s_frame_start !== 1'b0 || s_line_start !== 1'b0) begin errors++; $display("FAIL en_off_start: got %b/%b exp 0/0", s_frame_start, s_line_start); end
    checks++; if (s_rgb !== 16'h0) begin errors++; $display("FAIL en_off_rgb: got %h exp 0", s_rgb); end
    checks++; if (s_pix_x !== 12'hFFF || s_pix_y !== 12'hFFF) begin errors++; $display("FAIL en_off_xy: got %h/%h exp fff/fff", s_pix_x, s_pix_y); end
    s_en = 1'b1;
    @(negedge vga_clk);
    c = 0;
    for (int i = 0; i < 12; i++) begin
      checks++; if (s_frame_start !== (c == 0)) begin errors++; $display("FAIL en_on_frame_start c=%0d: got %b exp %b", c, s_frame_start, (c == 0)); end
      checks++; if (s_line_start !== (c % 10 == 0)) begin errors++; $display("FAIL en_on_line_start c=%0d: got %b exp %b", c, s_line_start, (c % 10 == 0)); end
      checks++; if (s_hsync !== (c % 10 < 2)) begin errors++; $display("FAIL en_on_hsync c=%0d: got %b exp %b", c, s_hsync, (c % 10 < 2)); end
      checks++; if (s_vsync !== (c < 10)) begin errors++; $display("FAIL en_on_vsync c=%0d: got %b exp %b", c, s_vsync, (c < 10)); end
      @(negedge vga_clk); c++;
    end
  endtask

  task automatic test_async_reset;
    while (c % 60 != 25) begin
      @(negedge vga_clk); c++;
    end
    checks++; if (s_pix_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b exp 1", s_pix_valid); end
    #2;
    s_rst = 1'b1;
    #1;
    checks++; if (s_pix_valid !== 1'b0 || s_pix_req !== 1'b0) begin errors++; $display("FAIL ar_strobe: got %b/%b exp 0/0", s_pix_valid, s_pix_req); end
    checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin errors++; $display("FAIL ar_sync: got %b/%b exp 0/0", s_hsync, s_vsync); end
    checks++; if (s_rgb !== 16'h0) begin errors++; $display("FAIL ar_rgb: got %h exp 0", s_rgb); end
    checks++; if (s_pix_x !== 12'hFFF) begin errors++; $display("FAIL ar_pix_x: got %h exp fff", s_pix_x); end
    checks++; if (s_frame_start !== 1'b0 || s_line_start !== 1'b0) begin errors++; $display("FAIL ar_start: got %b/%b exp 0/0", s_frame_start, s_line_start); end
    repeat (5) @(negedge vga_clk);
    checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin errors++; $display("FAIL ar_hold_sync: got %b/%b exp 0/0", s_hsync, s_vsync); end
    checks++; if (s_pix_y !== 12'hFFF) begin errors++; $display("FAIL ar_hold_pix_y: got %h exp fff", s_pix_y); end
    s_rst = 1'b0;
    @(negedge vga_clk);
    checks++; if (s_frame_start !== 1'b1) begin errors++; $display("FAIL ar_rel_frame_start: got %b exp 1", s_frame_start); end
    checks++; if (s_hsync !== 1'b1 || s_vsync !== 1'b1) begin errors++; $display("FAIL ar_rel_sync: got %b/%b exp 1/1", s_hsync, s_vsync); end
    @(negedge vga_clk);
    checks++; if (s_frame_start !== 1'b0 || s_line_start !== 1'b0) begin errors++; $display("FAIL ar_rel2_start: got %b/%b exp 0/0", s_frame_start, s_line_start); end
    checks++; if (s_hsync !== 1'b1) begin errors++; $display("FAIL ar_rel2_hsync: got %b exp 1", s_hsync); end
    @(negedge vga_clk);
    checks++; if (s_hsync !== 1'b0) begin errors++; $display("FAIL ar_rel3_hsync: got %b exp 0", s_hsync); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lines();
    test_pixels();
    test_small_frame();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
